// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end: redirect kinds, buffer entry layout
// and the pointer-width helper used by the prefetch FIFO.
package fetch_pkg;

  typedef enum logic [1:0] {
    RK_NONE   = 2'b00,
    RK_JUMP   = 2'b01,
    RK_JR     = 2'b10,
    RK_BRANCH = 2'b11
  } redir_kind_t;

  localparam int FETCH_ADDR_W  = 30;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_DEPTH   = 4;
  localparam int FETCH_PTR_W   = $clog2(FETCH_DEPTH);

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two synchronous FIFO of fetch entries with a
// dominant flush; head is combinational from the read pointer.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = ptr_w(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage carries no reset; entries are only observed behind count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pipe_unit.sv
// Pipelined fetch front end: word PC, credit-limited issue to a 1-cycle
// instruction memory, prefetch buffer towards decode, redirect handling.
module fetch_pipe_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 30,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redir_en,
  input  logic [1:0]         redir_kind,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic [15:0]        redir_imm16,
  input  logic [25:0]        redir_target26,
  input  logic [ADDR_W-1:0]  redir_reg,
  output logic [CNT_W-1:0]   redirect_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [ADDR_W-1:0] LO26 = ADDR_W'(27'h3FF_FFFF);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  redir_kind_t        kind;
  logic               redirect;
  logic [ADDR_W-1:0]  fetch_pc, pend_pc, pc_plus1, target;
  logic               pend_vld;
  logic [PW:0]        count;
  logic [PW+1:0]      occ;
  logic               credit_ok, fifo_empty, fifo_full, pop;
  entry_t             head, push_data;

  assign kind     = redir_kind_t'(redir_kind);
  assign redirect = reset && redir_en && (kind != RK_NONE);

  // Credit counts the response still on its way so the buffer never overflows.
  assign occ       = {1'b0, count} + (PW+2)'(pend_vld);
  assign credit_ok = occ < (PW+2)'(DEPTH);
  assign imem_en   = reset && !redirect && credit_ok && !fifo_full;
  assign imem_addr = fetch_pc;

  assign pc_plus1 = redir_pc + ADDR_W'(1);

  always_comb begin
    target = redir_reg;
    case (kind)
      RK_JUMP:   target = (pc_plus1 & ~LO26) | ADDR_W'(redir_target26);
      RK_JR:     target = redir_reg;
      RK_BRANCH: target = pc_plus1 + {{(ADDR_W-16){redir_imm16[15]}}, redir_imm16};
      default:   target = redir_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc       <= RESET_PC;
      pend_vld       <= 1'b0;
      pend_pc        <= '0;
      redirect_count <= '0;
    end else begin
      pend_vld <= imem_en;
      if (imem_en) pend_pc <= fetch_pc;
      if (redirect) begin
        fetch_pc <= target;
        if (redirect_count != '1) redirect_count <= redirect_count + CNT_W'(1);
      end else if (imem_en) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  // A response arriving in a redirect cycle is the killed in-flight fetch.
  assign push_data = '{pc: pend_pc, instr: imem_rdata};
  assign pop       = out_valid && out_ready;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (pend_vld && !redirect),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? '0 : head.instr;
  assign out_pc    = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_pipe_unit.sv
// Directed + randomized bench for fetch_pipe_unit against a stream-level
// model: expected pop/issue address sequences, occupancy credit, counter.
module tb_fetch_pipe_unit;

  localparam int AW    = 30;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          redir_en = 1'b0;
  logic [1:0]    redir_kind = 2'b00;
  logic [AW-1:0] redir_pc = '0;
  logic [15:0]   redir_imm16 = '0;
  logic [25:0]   redir_target26 = '0;
  logic [AW-1:0] redir_reg = '0;
  logic [CW-1:0] redirect_count;

  fetch_pipe_unit #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DEPTH), .RESET_PC('0), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .redir_en(redir_en),
    .redir_kind(redir_kind), .redir_pc(redir_pc), .redir_imm16(redir_imm16),
    .redir_target26(redir_target26), .redir_reg(redir_reg),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ifn(input logic [AW-1:0] a);
    return {2'b00, a} + 32'h1000;
  endfunction

  // Instruction memory: data valid the cycle after the request.
  always @(posedge clk) if (imem_en) imem_rdata <= ifn(imem_addr);

  int compared = 0, mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] tgt(input logic [1:0] k, input logic [AW-1:0] pc,
                                        input logic [15:0] imm, input logic [25:0] t26,
                                        input logic [AW-1:0] rg);
    longint m, p1, s, r;
    m  = longint'(1) << AW;
    p1 = (longint'(pc) + 1) % m;
    case (k)
      2'b01:   r = (p1 / (longint'(1) << 26)) * (longint'(1) << 26) + longint'(t26);
      2'b10:   r = longint'(rg);
      default: begin
        s = imm[15] ? longint'(imm) - 65536 : longint'(imm);
        r = (p1 + s + m) % m;
      end
    endcase
    return AW'(r);
  endfunction

  // Stream model: next address expected at the output and at the request port,
  // requests issued but not yet consumed, redirect counter.
  logic [AW-1:0] m_pop_pc, m_issue_pc, h_pc;
  logic [IW-1:0] h_instr;
  int            m_out, m_cnt, n_issue;
  bit            m_hold, m_post;

  task automatic model_reset();
    m_pop_pc = '0; m_issue_pc = '0; m_out = 0; m_cnt = 0;
    m_hold = 0; m_post = 0;
  endtask

  task automatic cycle();
    bit hon, pop, en_exp;
    #1;
    hon    = redir_en && (redir_kind != 2'b00);
    pop    = out_valid && out_ready;
    en_exp = !hon && (m_out < DEPTH);
    if (m_post) chk("post_redir_valid", out_valid, 0);
    if (m_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, h_pc);
      chk("hold_instr", out_instr, h_instr);
    end
    chk("redirect_count", redirect_count, m_cnt);
    chk("imem_en", imem_en, en_exp);
    if (imem_en) chk("imem_addr", imem_addr, m_issue_pc);
    if (pop) begin
      chk("out_pc", out_pc, m_pop_pc);
      chk("out_instr", out_instr, ifn(m_pop_pc));
      m_pop_pc++;
      m_out--;
    end
    n_issue += int'(imem_en);
    if (en_exp) begin m_issue_pc++; m_out++; end
    if (hon) begin
      m_pop_pc   = tgt(redir_kind, redir_pc, redir_imm16, redir_target26, redir_reg);
      m_issue_pc = m_pop_pc;
      m_out      = 0;
      if (m_cnt < CMAX) m_cnt++;
    end
    m_post  = hon;
    m_hold  = out_valid && !out_ready && !hon;
    h_pc    = out_pc;
    h_instr = out_instr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    redir_en = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      chk("rst_imem_en", imem_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_count", redirect_count, 0);
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    bit found;
    model_reset();
    n_issue = 0;

    // Reset, then streaming with latency N -> N+2.
    out_ready = 1'b1;
    @(negedge clk);
    do_reset(3);
    cycle();
    chk("lat_c1_valid", out_valid, 0);
    cycle();
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_pc", out_pc, 0);
    chk("lat_c2_instr", out_instr, 32'h1000);
    repeat (8) begin
      chk("stream_en", imem_en, 1);
      chk("stream_valid", out_valid, 1);
      cycle();
    end

    // Backpressure from reset: exactly DEPTH requests, then drain.
    out_ready = 1'b0;
    do_reset(3);
    n_issue = 0;
    repeat (10) cycle();
    chk("bp_issues", n_issue, DEPTH);
    chk("bp_en_idle", imem_en, 0);
    chk("bp_head_pc", out_pc, 0);
    out_ready = 1'b1;
    repeat (10) cycle();

    // Taken branch: 5 + 1 - 2 = 4.
    redir_en = 1'b1; redir_kind = 2'b11; redir_pc = 30'd5; redir_imm16 = 16'hFFFE;
    cycle();
    redir_en = 1'b0;
    #1;
    chk("br_en", imem_en, 1);
    chk("br_addr", imem_addr, 4);
    chk("br_valid", out_valid, 0);
    chk("br_count", redirect_count, 1);
    repeat (6) cycle();

    // Jump from the top of the address space wraps the upper bits to zero.
    redir_en = 1'b1; redir_kind = 2'b01; redir_pc = 30'h3FFF_FFFF; redir_target26 = 26'h10;
    cycle();
    redir_en = 1'b0;
    #1;
    chk("jmp_addr", imem_addr, 30'h10);
    repeat (4) cycle();

    redir_en = 1'b1; redir_kind = 2'b10; redir_reg = 30'h123;
    cycle();
    redir_en = 1'b0;
    #1;
    chk("jr_addr", imem_addr, 30'h123);
    repeat (4) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redir_en       = 1'b1;
        redir_kind     = 2'($urandom_range(0, 3));
        redir_pc       = AW'($urandom);
        redir_imm16    = 16'($urandom);
        redir_target26 = 26'($urandom);
        redir_reg      = AW'($urandom);
      end else begin
        redir_en = 1'b0;
      end
      cycle();
    end
    redir_en = 1'b0;

    // Counter saturation, then a kind=00 pulse on a full buffer.
    out_ready = 1'b1;
    do_reset(2);
    for (int i = 0; i < (1 << CW) + 5; i++) begin
      redir_en = 1'b1; redir_kind = 2'b10; redir_reg = AW'($urandom_range(0, 4095));
      cycle();
    end
    redir_en = 1'b0;
    #1;
    chk("sat_count", redirect_count, CMAX);
    out_ready = 1'b0;
    repeat (6) cycle();
    redir_en = 1'b1; redir_kind = 2'b00;
    cycle();
    redir_en = 1'b0;
    #1;
    chk("k0_valid", out_valid, 1);
    chk("k0_count", redirect_count, CMAX);
    repeat (2) cycle();

    // Async reset with 3 entries buffered and a response in flight.
    redir_en = 1'b1; redir_kind = 2'b10; redir_reg = 30'h200;
    cycle();
    redir_en = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid === 1'b1 && imem_en === 1'b0) found = 1;
      else cycle();
    end
    chk("ar_prep", found, 1);
    chk("ar_prep_pc", out_pc, 30'h200);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_en", imem_en, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_count", redirect_count, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ar_hold_valid", out_valid, 0);
    reset = 1'b1;
    model_reset();
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("ar_restart_valid", out_valid, 1);
    chk("ar_restart_pc", out_pc, 0);
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
